// File: rtl/rat_flags_if.sv
// rat_flags_if: groups the ALU, control-unit and interrupt signals of the
// RAT MCU flag block. The control side (master) drives commands and ALU
// results; the flag block (slave) returns the flag registers and INT_REQ.
interface rat_flags_if;
  logic ALU_C;
  logic ALU_Z;
  logic FLG_C_LD;
  logic FLG_C_SET;
  logic FLG_C_CLR;
  logic FLG_Z_LD;
  logic FLG_LD_SEL;
  logic FLG_SHAD_LD;
  logic I_SET;
  logic I_CLR;
  logic INTR_IN;
  logic INT_ACK;
  logic C_FLAG;
  logic Z_FLAG;
  logic I_FLAG;
  logic SHAD_C;
  logic SHAD_Z;
  logic INT_REQ;

  modport master (
    output ALU_C, ALU_Z, FLG_C_LD, FLG_C_SET, FLG_C_CLR, FLG_Z_LD,
           FLG_LD_SEL, FLG_SHAD_LD, I_SET, I_CLR, INTR_IN, INT_ACK,
    input  C_FLAG, Z_FLAG, I_FLAG, SHAD_C, SHAD_Z, INT_REQ
  );

  modport slave (
    input  ALU_C, ALU_Z, FLG_C_LD, FLG_C_SET, FLG_C_CLR, FLG_Z_LD,
           FLG_LD_SEL, FLG_SHAD_LD, I_SET, I_CLR, INTR_IN, INT_ACK,
    output C_FLAG, Z_FLAG, I_FLAG, SHAD_C, SHAD_Z, INT_REQ
  );
endinterface

// File: rtl/rat_flags.sv
// rat_flags: C/Z flag registers with shadow copies for interrupt entry and
// return, the interrupt-enable flag I, and a one-deep edge-triggered
// interrupt-pending latch. Every output is a register or a function of
// registers only, so there is no input-to-output combinational path.
module rat_flags (
  input logic         CLK,
  input logic         RST,
  rat_flags_if.slave  bus
);

  logic c_flag_q, c_flag_d;
  logic z_flag_q, z_flag_d;
  logic i_flag_q, i_flag_d;
  logic shad_c_q, shad_c_d;
  logic shad_z_q, shad_z_d;
  logic pend_q, pend_d;
  logic intr_prev_q, intr_prev_d;
  logic ld_src_c;
  logic ld_src_z;
  logic rise;

  // Next-state logic for flags, shadows, interrupt enable and pending latch.
  always_comb begin
    ld_src_c    = bus.FLG_LD_SEL ? shad_c_q : bus.ALU_C;
    ld_src_z    = bus.FLG_LD_SEL ? shad_z_q : bus.ALU_Z;
    rise        = bus.INTR_IN & ~intr_prev_q;
    intr_prev_d = bus.INTR_IN;

    c_flag_d = c_flag_q;
    if (bus.FLG_C_CLR)      c_flag_d = 1'b0;
    else if (bus.FLG_C_SET) c_flag_d = 1'b1;
    else if (bus.FLG_C_LD)  c_flag_d = ld_src_c;

    z_flag_d = z_flag_q;
    if (bus.FLG_Z_LD) z_flag_d = ld_src_z;

    shad_c_d = shad_c_q;
    shad_z_d = shad_z_q;
    if (bus.FLG_SHAD_LD) begin
      shad_c_d = c_flag_q;
      shad_z_d = z_flag_q;
    end

    i_flag_d = i_flag_q;
    if (bus.INT_ACK)    i_flag_d = 1'b0;
    else if (bus.I_CLR) i_flag_d = 1'b0;
    else if (bus.I_SET) i_flag_d = 1'b1;

    pend_d = pend_q;
    if (rise)             pend_d = 1'b1;
    else if (bus.INT_ACK) pend_d = 1'b0;
  end

  // State registers; synchronous reset clears everything including pending.
  always_ff @(posedge CLK) begin
    if (RST) begin
      c_flag_q    <= 1'b0;
      z_flag_q    <= 1'b0;
      i_flag_q    <= 1'b0;
      shad_c_q    <= 1'b0;
      shad_z_q    <= 1'b0;
      pend_q      <= 1'b0;
      intr_prev_q <= 1'b0;
    end else begin
      c_flag_q    <= c_flag_d;
      z_flag_q    <= z_flag_d;
      i_flag_q    <= i_flag_d;
      shad_c_q    <= shad_c_d;
      shad_z_q    <= shad_z_d;
      pend_q      <= pend_d;
      intr_prev_q <= intr_prev_d;
    end
  end

  // Outputs come straight from registers; the request is gated by enable.
  always_comb begin
    bus.C_FLAG  = c_flag_q;
    bus.Z_FLAG  = z_flag_q;
    bus.I_FLAG  = i_flag_q;
    bus.SHAD_C  = shad_c_q;
    bus.SHAD_Z  = shad_z_q;
    bus.INT_REQ = pend_q & i_flag_q;
  end

endmodule

// File: doc/rat_flags.md
# rat_flags

Flag and interrupt-status register block for the RAT MCU. It captures the C and Z outputs of the ALU under control-unit command and keeps shadow copies of C/Z for interrupt entry and return. It also holds the interrupt-enable flag I and a one-deep edge-triggered interrupt-pending latch. It sits between the ALU, the control unit and the external interrupt pin, and feeds C_FLAG/Z_FLAG back to the ALU carry-in and to the branch logic.

## Interface
- No parameters; all datapaths 1 bit.
- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- ALU_C  in  1  ALU carry/borrow output
- ALU_Z  in  1  ALU zero output
- FLG_C_LD  in  1  load C from source selected by FLG_LD_SEL
- FLG_C_SET  in  1  force C=1 (SEC)
- FLG_C_CLR  in  1  force C=0 (CLC)
- FLG_Z_LD  in  1  load Z from source selected by FLG_LD_SEL
- FLG_LD_SEL  in  1  0: load source is ALU_C/ALU_Z; 1: load source is SHAD_C/SHAD_Z
- FLG_SHAD_LD  in  1  copy current C_FLAG/Z_FLAG into shadows
- I_SET  in  1  set interrupt enable (SEI)
- I_CLR  in  1  clear interrupt enable (CLI)
- INTR_IN  in  1  external interrupt line, already synchronous to CLK
- INT_ACK  in  1  control unit is vectoring to the ISR this cycle
- C_FLAG  out  1  carry flag register
- Z_FLAG  out  1  zero flag register
- I_FLAG  out  1  interrupt-enable register
- SHAD_C  out  1  shadow carry register
- SHAD_Z  out  1  shadow zero register
- INT_REQ  out  1  interrupt request to control unit

## Operation
- All outputs except INT_REQ are registers; INT_REQ = pend & I_FLAG, combinational from registers only.
- Reset: C_FLAG, Z_FLAG, I_FLAG, SHAD_C, SHAD_Z, internal pend and intr_prev all 0; INT_REQ therefore 0.
- C_FLAG next-state priority: RST > FLG_C_CLR > FLG_C_SET > FLG_C_LD > hold.
- Z_FLAG next-state priority: RST > FLG_Z_LD > hold.
- Load source mux applies to both C and Z: FLG_LD_SEL=1 selects SHAD_C/SHAD_Z (RETID/RETIE restore).
- Shadow: on FLG_SHAD_LD, SHAD_C<=C_FLAG, SHAD_Z<=Z_FLAG. These are pre-edge register values, never ALU inputs. With FLG_SHAD_LD and FLG_C_LD in the same cycle, the shadow gets the old C and C gets the new value.
- Same-cycle FLG_SHAD_LD with FLG_LD_SEL=1 loads: flags and shadows swap values; this is legal and deterministic.
- I_FLAG priority: RST > INT_ACK (clear) > I_CLR > I_SET > hold.
- Edge detect: intr_prev <= INTR_IN every cycle; rise = INTR_IN & ~intr_prev.
- Pending latch priority: RST > rise (set) > INT_ACK (clear) > hold.
  - A new edge in the ACK cycle stays pending.
  - Edges while I_FLAG=0 are latched and held.
  - Multiple edges before ACK collapse to one.
- Level-held INTR_IN produces exactly one pending event.

## Timing
- Every flag change is visible one cycle after the command edge: command sampled at edge N, output valid after edge N.
- ALU_C/ALU_Z are sampled at the same edge as FLG_*_LD. They must be stable for the instruction's execute cycle.
- INTR_IN rising between edges N-1 and N: rise is seen at edge N, pend=1 after edge N, INT_REQ high after edge N if I_FLAG=1.
- INT_ACK at edge M: INT_REQ is 0 after edge M, because both pend and I_FLAG clear.
- RST asserted mid-operation wins over every command in that cycle. Pending interrupts and shadows are lost.
- No combinational path from any input to any output.

## Test plan
- Reset: drive every command high with RST=1 for 2 cycles -> all six outputs 0; release RST with commands low -> outputs hold 0.
- C priority: ALU_C=1 with FLG_C_LD=1 and FLG_C_CLR=1 -> C_FLAG=0. Next cycle FLG_C_SET=1, FLG_C_LD=1, ALU_C=0 -> C_FLAG=1. Then FLG_C_LD=1, ALU_C=0 -> C_FLAG=0.
- Shadow save/restore: C=1, Z=0; pulse FLG_SHAD_LD together with FLG_C_LD, FLG_Z_LD, ALU_C=0, ALU_Z=1 -> C=0, Z=1, SHAD_C=1, SHAD_Z=0. Pulse FLG_C_LD, FLG_Z_LD, FLG_LD_SEL=1 -> C=1, Z=0.
- Interrupt flow: I_SET pulse; raise INTR_IN and hold high 5 cycles -> INT_REQ=1 one edge later. Pulse INT_ACK -> INT_REQ=0 and I_FLAG=0. I_SET again with INTR_IN still high -> INT_REQ stays 0 (no new edge).
- Masked latch: I_FLAG=0, INTR_IN pulse 0->1->0 -> INT_REQ=0. I_SET -> INT_REQ=1 on the next cycle. Also: INT_ACK coincident with a new rise -> after the edge I_FLAG=0 and pend=1; after I_SET, INT_REQ=1.
- Reset mid-flight: pend=1, I_FLAG=1, SHAD_C=1; assert RST one cycle -> INT_REQ=0, SHAD_C=0, I_FLAG=0. INTR_IN held high through reset release gives no request.
